// File: rtl/abft_pkg.sv
// Shared definitions for the ABFT checksum encoder: default geometry,
// controller state encoding and a reference row-sum helper.
package abft_pkg;

    localparam int DW_DEFAULT    = 8;
    localparam int N_DEFAULT     = 4;
    localparam int SUM_W_DEFAULT = DW_DEFAULT + $clog2(N_DEFAULT);

    typedef enum logic [1:0] {
        ST_ROWS  = 2'd0,
        ST_CHK   = 2'd1,
        ST_DRAIN = 2'd2
    } enc_state_e;

    // Sum of the N default-width elements of a row, widened so it cannot overflow.
    function automatic logic [SUM_W_DEFAULT-1:0] sum_row(
        input logic [N_DEFAULT*DW_DEFAULT-1:0] row
    );
        logic [SUM_W_DEFAULT-1:0] acc;
        acc = '0;
        for (int j = 0; j < N_DEFAULT; j++) begin
            acc = acc + SUM_W_DEFAULT'(row[j*DW_DEFAULT +: DW_DEFAULT]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/abft_row_adder.sv
// Combinational N-input unsigned adder tree. Inputs are zero-extended to OW
// before summing; OW must be wide enough for N*(2^IW-1). N is a power of two.
module abft_row_adder #(
    parameter int N  = 4,
    parameter int IW = 8,
    parameter int OW = 10
) (
    input  logic [N*IW-1:0] in_vec,
    output logic [OW-1:0]   sum
);

    // Heap-ordered tree: leaves at [N-1 .. 2N-2], node i = child(2i+1) + child(2i+2).
    logic [OW-1:0] node [2*N-1];

    // Build the tree bottom-up.
    always_comb begin
        for (int i = 0; i < 2*N-1; i++) begin
            node[i] = '0;
        end
        for (int j = 0; j < N; j++) begin
            node[N-1+j] = OW'(in_vec[j*IW +: IW]);
        end
        for (int i = N-2; i >= 0; i--) begin
            node[i] = node[2*i+1] + node[2*i+2];
        end
    end

    assign sum = node[0];

endmodule

// File: rtl/abft_checksum_encoder.sv
// ABFT checksum encoder: widens each incoming row and attaches its row sum,
// then emits one checksum row (column sums + grand total) per N-row block.
// Optional fault injection on a chosen data element: ABFT_ENC_FAULT_INJ_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_ROWS  | accepting data rows, accumulating column sums
// ST_CHK   | all N rows taken; load checksum row once output slot frees
// ST_DRAIN | checksum row on the output, waiting for out_ready
module abft_checksum_encoder
    import abft_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int N  = N_DEFAULT,
    localparam int LGN = $clog2(N),
    localparam int CW  = DW + LGN,
    localparam int TW  = DW + 2*LGN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_row,
`ifdef ABFT_ENC_FAULT_INJ_EN
    input  logic            inj_en,
    input  logic [LGN-1:0]  inj_row,
    input  logic [LGN-1:0]  inj_col,
    input  logic [DW-1:0]   inj_mask,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*CW-1:0] out_row,
    output logic [TW-1:0]   out_rsum,
    output logic            out_chk,
    output logic            out_last
);

    enc_state_e      state_q, state_d;
    logic [LGN-1:0]  row_cnt_q, row_cnt_d;
    logic [N*CW-1:0] col_acc_q, col_acc_d;
    logic            out_valid_q, out_valid_d;
    logic [N*CW-1:0] out_row_q, out_row_d;
    logic [TW-1:0]   out_rsum_q, out_rsum_d;
    logic            out_chk_q, out_chk_d;

    logic [CW-1:0]   row_sum;
    logic [TW-1:0]   grand_sum;
    logic [N*CW-1:0] row_wide;
    logic [N*CW-1:0] row_emit;
    logic [N*CW-1:0] col_next;
    logic            slot_free;
    logic            accept;

    abft_row_adder #(.N(N), .IW(DW), .OW(CW)) u_row_sum (
        .in_vec (in_row),
        .sum    (row_sum)
    );

    abft_row_adder #(.N(N), .IW(CW), .OW(TW)) u_grand_sum (
        .in_vec (col_acc_q),
        .sum    (grand_sum)
    );

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q == ST_ROWS) && slot_free;
    assign accept    = in_valid && in_ready;

    // Zero-extend the incoming row and advance the column accumulators.
    always_comb begin
        row_wide = '0;
        col_next = '0;
        for (int j = 0; j < N; j++) begin
            row_wide[j*CW +: CW] = CW'(in_row[j*DW +: DW]);
            col_next[j*CW +: CW] = col_acc_q[j*CW +: CW] + CW'(in_row[j*DW +: DW]);
        end
    end

    // Emitted data row; an injected fault corrupts only the output copy so the
    // checksums stay clean and the downstream checker sees the discrepancy.
    always_comb begin
        row_emit = row_wide;
`ifdef ABFT_ENC_FAULT_INJ_EN
        if (inj_en && (inj_row == row_cnt_q)) begin
            row_emit[int'(inj_col)*CW +: CW] = row_wide[int'(inj_col)*CW +: CW] ^ CW'(inj_mask);
        end
`endif
    end

    // Next-state and output-register load logic.
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        col_acc_d   = col_acc_q;
        out_valid_d = out_valid_q;
        out_row_d   = out_row_q;
        out_rsum_d  = out_rsum_q;
        out_chk_d   = out_chk_q;

        case (state_q)
            ST_ROWS: begin
                if (accept) begin
                    out_row_d   = row_emit;
                    out_rsum_d  = TW'(row_sum);
                    col_acc_d   = col_next;
                    row_cnt_d   = row_cnt_q + 1'b1;
                    out_valid_d = 1'b1;
                    out_chk_d   = 1'b0;
                    if (row_cnt_q == LGN'(N-1)) begin
                        state_d = ST_CHK;
                    end
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            ST_CHK: begin
                if (slot_free) begin
                    out_row_d   = col_acc_q;
                    out_rsum_d  = grand_sum;
                    out_chk_d   = 1'b1;
                    out_valid_d = 1'b1;
                    col_acc_d   = '0;
                    row_cnt_d   = '0;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_chk_d   = 1'b0;
                    state_d     = ST_ROWS;
                end
            end
            default: begin
                state_d = ST_ROWS;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ROWS;
            row_cnt_q   <= '0;
            col_acc_q   <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_rsum_q  <= '0;
            out_chk_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            col_acc_q   <= col_acc_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            out_rsum_q  <= out_rsum_d;
            out_chk_q   <= out_chk_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign out_rsum  = out_rsum_q;
    assign out_chk   = out_chk_q;
    assign out_last  = out_chk_q;

endmodule

// File: tb/tb_abft_checksum_encoder.sv
// Scoreboard bench for abft_checksum_encoder. Define ABFT_ENC_FAULT_INJ_EN to
// also exercise the fault-injection ports.
module tb_abft_checksum_encoder;
    import abft_pkg::*;

    localparam int DW  = DW_DEFAULT;
    localparam int N   = N_DEFAULT;
    localparam int LGN = $clog2(N);
    localparam int CW  = DW + LGN;
    localparam int TW  = DW + 2*LGN;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_row;
    logic            out_valid;
    logic            out_ready;
    logic [N*CW-1:0] out_row;
    logic [TW-1:0]   out_rsum;
    logic            out_chk;
    logic            out_last;
`ifdef ABFT_ENC_FAULT_INJ_EN
    logic            inj_en;
    logic [LGN-1:0]  inj_row;
    logic [LGN-1:0]  inj_col;
    logic [DW-1:0]   inj_mask;
`endif

    always #5 clk = ~clk;

    abft_checksum_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
`ifdef ABFT_ENC_FAULT_INJ_EN
        .inj_en    (inj_en),
        .inj_row   (inj_row),
        .inj_col   (inj_col),
        .inj_mask  (inj_mask),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_rsum  (out_rsum),
        .out_chk   (out_chk),
        .out_last  (out_last)
    );

    typedef struct {
        logic [N*CW-1:0] row;
        logic [TW-1:0]   rsum;
        logic            chk;
    } beat_t;

    beat_t           exp_q[$];
    beat_t           obs_q[$];
    logic [N*DW-1:0] stim_q[$];
    logic [CW-1:0]   mdl_col[N];
    int              mdl_rows;

    int n_checks = 0;
    int n_pass   = 0;

    int cyc = 0;
    int stall_left = 0;
    int stall_en = 0;
    int bubble_en = 0;
    int beats_in_block = 0;
    int last_fire_chk = 0;
    int chk_cyc = 0;
    logic            prev_valid = 1'b0;
    logic            prev_ready = 1'b1;
    logic [N*CW-1:0] prev_row = '0;
    logic [TW-1:0]   prev_rsum = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [CW-1:0] col_of(input beat_t b, input int j);
        return b.row[j*CW +: CW];
    endfunction

    function automatic void model_clear();
        for (int j = 0; j < N; j++) mdl_col[j] = '0;
        mdl_rows = 0;
    endfunction

    // Expected output for an accepted row, plus the checksum beat after the Nth row.
    function automatic void model_accept(input logic [N*DW-1:0] row);
        beat_t b;
        beat_t c;
        logic [CW-1:0] e;
        logic [TW-1:0] s;
        s = '0;
        b.row = '0;
        b.chk = 1'b0;
        for (int j = 0; j < N; j++) begin
            e = CW'(row[j*DW +: DW]);
            b.row[j*CW +: CW] = e;
            s = s + TW'(e);
            mdl_col[j] = mdl_col[j] + e;
        end
        b.rsum = s;
`ifdef ABFT_ENC_FAULT_INJ_EN
        if (inj_en && int'(inj_row) == mdl_rows)
            b.row[int'(inj_col)*CW +: CW] = b.row[int'(inj_col)*CW +: CW] ^ CW'(inj_mask);
`endif
        exp_q.push_back(b);
        mdl_rows++;
        if (mdl_rows == N) begin
            s = '0;
            c.row = '0;
            for (int j = 0; j < N; j++) begin
                c.row[j*CW +: CW] = mdl_col[j];
                s = s + TW'(mdl_col[j]);
            end
            c.rsum = s;
            c.chk = 1'b1;
            exp_q.push_back(c);
            model_clear();
        end
    endfunction

    task automatic step();
        beat_t b;
        beat_t o;
        @(negedge clk);
        in_valid  = (stim_q.size() > 0);
        in_row    = in_valid ? stim_q[0] : $urandom;
        out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        #1;
        cyc++;
        if (prev_valid && !prev_ready) begin
            check_val("hold_valid", out_valid, 1);
            check_val("hold_row", out_row, prev_row);
            check_val("hold_rsum", out_rsum, prev_rsum);
        end
        if (out_valid && !out_ready) check_val("stall_in_ready", in_ready, 0);
        if (out_valid && out_ready) begin
            o.row = out_row;
            o.rsum = out_rsum;
            o.chk = out_chk;
            obs_q.push_back(o);
            if (exp_q.size() == 0) begin
                check_val("unexpected_beat", 1, 0);
            end else begin
                b = exp_q.pop_front();
                check_val("row", out_row, b.row);
                check_val("rsum", out_rsum, b.rsum);
                check_val("chk", out_chk, b.chk);
                check_val("last", out_last, b.chk);
            end
            if (bubble_en && last_fire_chk) check_val("bubble_gap", cyc - chk_cyc, 2);
            last_fire_chk = out_chk;
            if (out_chk) begin
                chk_cyc = cyc;
                beats_in_block = 0;
            end else begin
                beats_in_block++;
                if (stall_en && beats_in_block == 2) stall_left = 3;
            end
        end
        if (in_valid && in_ready) model_accept(stim_q.pop_front());
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_row   = out_row;
        prev_rsum  = out_rsum;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        check_val("drain_timeout", stim_q.size() + exp_q.size(), 0);
        step();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_chk", out_chk, 0);
        check_val("rst_out_last", out_last, 0);
        check_val("rst_out_row", out_row, 0);
        check_val("rst_out_rsum", out_rsum, 0);
        check_val("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        model_clear();
        prev_valid = 1'b0;
        prev_ready = 1'b1;
        stall_left = 0;
        beats_in_block = 0;
        last_fire_chk = 0;
    endtask

    function automatic logic [N*DW-1:0] seq_row(input int r);
        logic [N*DW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(r*N + j + 1);
        return v;
    endfunction

    function automatic logic [N*DW-1:0] fill_row(input int x);
        logic [N*DW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(x);
        return v;
    endfunction

    task automatic push_seq_block();
        for (int r = 0; r < N; r++) stim_q.push_back(seq_row(r));
    endtask

    task automatic push_fill_block(input int x);
        for (int r = 0; r < N; r++) stim_q.push_back(fill_row(x));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_row = '0;
        out_ready = 1'b1;
`ifdef ABFT_ENC_FAULT_INJ_EN
        inj_en = 1'b0;
        inj_row = '0;
        inj_col = '0;
        inj_mask = '0;
`endif
        model_clear();
        apply_reset();

        // Sequential matrix
        push_seq_block();
        drain(100);
        check_val("t1_beats", obs_q.size(), 5);
        if (obs_q.size() == 5) begin
            check_val("t1_rsum0", obs_q[0].rsum, 10);
            check_val("t1_rsum1", obs_q[1].rsum, 26);
            check_val("t1_rsum2", obs_q[2].rsum, 42);
            check_val("t1_rsum3", obs_q[3].rsum, 58);
            check_val("t1_col0", col_of(obs_q[4], 0), 28);
            check_val("t1_col1", col_of(obs_q[4], 1), 32);
            check_val("t1_col2", col_of(obs_q[4], 2), 36);
            check_val("t1_col3", col_of(obs_q[4], 3), 40);
            check_val("t1_total", obs_q[4].rsum, 136);
            check_val("t1_chk", obs_q[4].chk, 1);
        end
        obs_q.delete();

        // All-ones-at-max: widest sums
        push_fill_block(255);
        drain(100);
        check_val("t2_beats", obs_q.size(), 5);
        if (obs_q.size() == 5) begin
            check_val("t2_rsum0", obs_q[0].rsum, 1020);
            for (int j = 0; j < N; j++) check_val("t2_col", col_of(obs_q[4], j), 1020);
            check_val("t2_total", obs_q[4].rsum, 4080);
        end
        obs_q.delete();

        // Back-pressure for 3 cycles after the second row
        stall_en = 1;
        push_seq_block();
        drain(100);
        stall_en = 0;
        check_val("t3_beats", obs_q.size(), 5);
        if (obs_q.size() == 5) check_val("t3_total", obs_q[4].rsum, 136);
        obs_q.delete();

        // Abort a block with reset, then a fresh block of ones
        stim_q.push_back(seq_row(0));
        stim_q.push_back(seq_row(1));
        for (int k = 0; k < 6; k++) step();
        apply_reset();
        push_fill_block(1);
        drain(100);
        check_val("t4_beats", obs_q.size(), 5);
        if (obs_q.size() == 5) begin
            for (int j = 0; j < N; j++) check_val("t4_col", col_of(obs_q[4], j), 4);
            check_val("t4_total", obs_q[4].rsum, 16);
        end
        obs_q.delete();

`ifdef ABFT_ENC_FAULT_INJ_EN
        // Fault injected on row 1, column 1
        inj_en = 1'b1;
        inj_row = LGN'(1);
        inj_col = LGN'(1);
        inj_mask = 8'h0F;
        push_seq_block();
        drain(100);
        inj_en = 1'b0;
        check_val("t5_beats", obs_q.size(), 5);
        if (obs_q.size() == 5) begin
            check_val("t5_elem", col_of(obs_q[1], 1), 9);
            check_val("t5_rsum", obs_q[1].rsum, 26);
            check_val("t5_col1", col_of(obs_q[4], 1), 32);
        end
        obs_q.delete();
`endif

        // Back-to-back blocks with in_valid held high
        last_fire_chk = 0;
        bubble_en = 1;
        push_seq_block();
        push_fill_block(1);
        drain(200);
        bubble_en = 0;
        check_val("t6_beats", obs_q.size(), 10);
        if (obs_q.size() == 10) begin
            check_val("t6_total_a", obs_q[4].rsum, 136);
            check_val("t6_total_b", obs_q[9].rsum, 16);
            check_val("t6_col_b", col_of(obs_q[9], 0), 4);
        end
        obs_q.delete();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
